// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory sequencer state encoding and default sizes.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  localparam int DMEM_ADDR_W      = 32;
  localparam int DMEM_DATA_W      = 32;
  localparam int DMEM_TIMEOUT_CYC = 64;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Access watchdog for dmem_access_ctrl (DMEM_TIMEOUT_EN builds): reloads on clear,
// counts down while enabled, and flags the cycle in which the budget runs out.
module dmem_timeout_cnt
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = DMEM_TIMEOUT_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt <= LOAD_VAL;
    end else if (en_i && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Terminal count reached on the TIMEOUT_CYC-th enabled cycle.
  assign expired_o = en_i && (cnt == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: turns MemRead/MemWrite into a req/ack
// transaction and stalls the pipeline meanwhile. Optional watchdog: DMEM_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no access outstanding; a memory op here is latched and issued
// ACCESS | mem_req_o held with stable addr/data/we until ack (or timeout)
// DONE   | result presented to MEM/WB; instruction leaves EX/MEM this cycle
module dmem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int TIMEOUT_CYC = DMEM_TIMEOUT_CYC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic              err_o
);

  dmem_state_t state;
  logic        mem_op;
  logic        timeout_hit;

  assign mem_op = MemRead_i | MemWrite_i;

  assign stall_o = !rst_i && (((state == IDLE) && mem_op) || (state == ACCESS));

`ifdef DMEM_TIMEOUT_EN
  logic err_q;

  dmem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state != ACCESS),
    .en_i      (state == ACCESS),
    .expired_o (timeout_hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((state == ACCESS) && !mem_ack_i && timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      ReadData_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            // A simultaneous read+write intent resolves to a write.
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            mem_we_o    <= MemWrite_i;
            mem_req_o   <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            if (!mem_we_o) begin
              ReadData_o <= mem_rdata_i;
            end
            mem_req_o <= 1'b0;
            state     <= DONE;
          end else if (timeout_hit) begin
            ReadData_o <= '0;
            mem_req_o  <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          mem_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_dmem_access_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          MemRead_i, MemWrite_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_o;
  logic [DW-1:0] ReadData_o;
  logic          err_o;

  dmem_access_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .ReadData_o  (ReadData_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: last load result, sticky error, transactions issued.
  logic [DW-1:0] model_rdata = '0;
  logic          model_err   = 1'b0;
  int            model_txns  = 0;

  int   req_rises = 0;
  logic req_q     = 1'b0;

  always @(posedge clk_i) begin
    if (mem_req_o && !req_q) req_rises++;
    req_q = mem_req_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One complete transaction; returns with the inputs cleared at the start of
  // the IDLE cycle following DONE, so a caller can issue back-to-back ops.
  task automatic run_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int k, input logic [DW-1:0] rdat);
    int stalls = 0;
    int reqs   = 0;
    bit is_wr  = wr;
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = d;
    mem_ack_i  = 1'b0;
    model_txns++;
    @(negedge clk_i);
    check("issue_req_low", 64'(mem_req_o), 64'(1'b0));
    if (stall_o) stalls++;
    for (int c = 1; c <= k; c++) begin
      next_cycle();
      mem_ack_i   = (c == k);
      mem_rdata_i = (c == k) ? rdat : $urandom;
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (mem_req_o) reqs++;
      check("access_addr", 64'(mem_addr_o), 64'(a));
      check("access_we", 64'(mem_we_o), 64'(is_wr));
      if (is_wr) check("access_wdata", 64'(mem_wdata_o), 64'(d));
    end
    next_cycle();
    mem_ack_i = 1'b0;
    if (!is_wr) model_rdata = rdat;
    @(negedge clk_i);
    check("done_stall", 64'(stall_o), 64'(1'b0));
    check("done_req", 64'(mem_req_o), 64'(1'b0));
    check("done_rdata", 64'(ReadData_o), 64'(model_rdata));
    check("done_err", 64'(err_o), 64'(model_err));
    check("stall_cycles", 64'(stalls), 64'(k + 1));
    check("req_cycles", 64'(reqs), 64'(k));
    next_cycle();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  initial begin
    bit rd, wr;
    int gap;
    rst_i       = 1'b1;
    MemRead_i   = 1'b1;
    MemWrite_i  = 1'b0;
    addr_i      = 32'h55;
    wdata_i     = 32'h66;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;

    // Reset: outputs cleared, stall suppressed even with a load presented.
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    check("rst_stall", 64'(stall_o), 64'(1'b0));
    check("rst_req", 64'(mem_req_o), 64'(1'b0));
    check("rst_we", 64'(mem_we_o), 64'(1'b0));
    check("rst_addr", 64'(mem_addr_o), 64'(0));
    check("rst_wdata", 64'(mem_wdata_o), 64'(0));
    check("rst_rdata", 64'(ReadData_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(1'b0));
    next_cycle();
    rst_i     = 1'b0;
    MemRead_i = 1'b0;
    next_cycle();

    // Directed: slow load, fast store, back-to-back load/store/load.
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    run_op(1'b0, 1'b1, 32'h04, 32'h12345678, 1, 32'hCAFEF00D);
    run_op(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h11112222);
    run_op(1'b0, 1'b1, 32'h204, 32'hA5A5A5A5, 1, 32'h33334444);
    run_op(1'b1, 1'b0, 32'h208, 32'h0, 1, 32'h55556666);
    run_op(1'b1, 1'b1, 32'h20C, 32'h77778888, 2, 32'h9999AAAA);

    // Spurious ack in IDLE with no memory op.
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0BAD0;
    @(negedge clk_i);
    check("spur_stall", 64'(stall_o), 64'(1'b0));
    next_cycle();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    check("spur_req", 64'(mem_req_o), 64'(1'b0));
    check("spur_rdata", 64'(ReadData_o), 64'(model_rdata));

    // Reset during the second ACCESS cycle, late ack afterwards.
    next_cycle();
    MemRead_i = 1'b1;
    addr_i    = 32'h300;
    model_txns++;
    next_cycle();
    next_cycle();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rstacc_stall", 64'(stall_o), 64'(1'b0));
    next_cycle();
    rst_i       = 1'b0;
    MemRead_i   = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFEEDFACE;
    model_rdata = '0;
    model_err   = 1'b0;
    @(negedge clk_i);
    check("rstacc_req", 64'(mem_req_o), 64'(1'b0));
    check("rstacc_idle_stall", 64'(stall_o), 64'(1'b0));
    next_cycle();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    check("late_ack_req", 64'(mem_req_o), 64'(1'b0));
    check("late_ack_rdata", 64'(ReadData_o), 64'(0));
    next_cycle();

`ifdef DMEM_TIMEOUT_EN
    // Watchdog: no ack; request must drop after exactly TO ACCESS cycles.
    begin
      int  reqs = 0;
      bit  done = 1'b0;
      MemRead_i = 1'b1;
      addr_i    = 32'h400;
      model_txns++;
      for (int c = 0; c < 3 * TO && !done; c++) begin
        next_cycle();
        @(negedge clk_i);
        if (mem_req_o) reqs++;
        else done = 1'b1;
      end
      model_rdata = '0;
      model_err   = 1'b1;
      check("to_req_cycles", 64'(reqs), 64'(TO));
      check("to_stall", 64'(stall_o), 64'(1'b0));
      check("to_rdata", 64'(ReadData_o), 64'(0));
      check("to_err", 64'(err_o), 64'(1'b1));
      next_cycle();
      MemRead_i = 1'b0;
      next_cycle();
    end
`endif

    // Randomized transactions with idle gaps and stray acks.
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_ack_i   = $urandom_range(0, 1) == 1;
        mem_rdata_i = $urandom;
        @(negedge clk_i);
        check("gap_stall", 64'(stall_o), 64'(1'b0));
        next_cycle();
        mem_ack_i = 1'b0;
      end
      rd = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 1) == 1;
      if (!rd && !wr) rd = 1'b1;
      run_op(rd, wr, $urandom, $urandom, $urandom_range(1, 5), $urandom);
    end

    @(negedge clk_i);
    check("txn_count", 64'(req_rises), 64'(model_txns));
    check("final_err", 64'(err_o), 64'(model_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
